uart_tx_report: RTL

//   UART transmitter returning the live configuration parameters to the host as ASCII.
//   It is the transmit-side counterpart of the ASCII-decimal UART parameter receiver.
//   On a start request it snapshots PAR_N parameters and converts each to decimal by double-dabble.
//   It sends them as "p0_p1_..._pN-1\n" in 8N1 frames, LSB first.

---
 rtl/uart_tx_report.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_report.sv
// UART transmitter that reports PAR_N snapshotted parameters as ASCII decimal,
// formatted "p0_p1_..._pN-1\n", 8N1, LSB first.
module uart_tx_report #(
  parameter int CLK_DIV = 16,
  parameter int PAR_W   = 16,
  parameter int PAR_N   = 5,
  parameter int DIGITS  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PAR_N*PAR_W-1:0] params,
  output logic                   busy,
  output logic                   done,
  output logic                   uart_tx
);

  localparam int CW    = $clog2(PAR_W + 1);
  localparam int BW    = $clog2(CLK_DIV + 1);
  localparam int IW    = (PAR_N > 1) ? $clog2(PAR_N) : 1;
  localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LOAD,
    S_SEND
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PAR_N*PAR_W-1:0] r_snap;
  logic [IW-1:0]          r_idx;
  logic [PAR_W-1:0]       r_shift;
  logic [BCD_W-1:0]       r_bcd;
  logic [CW-1:0]          r_cnt;
  logic [DW-1:0]          r_dptr;
  logic                   r_dig_pend;
  logic                   r_sep_sent;
  logic [9:0]             r_frame;
  logic [BW-1:0]          r_baud;
  logic [3:0]             r_bit;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;

  logic [BCD_W-1:0]       w_bcd_adj;
  logic [BCD_W-1:0]       w_bcd_next;
  logic [DW-1:0]          w_msd;
  logic [3:0]             w_digit;
  logic [7:0]             w_char;
  logic                   w_last_par;
  logic                   w_last_char;
  logic                   w_conv_last;
  logic                   w_frame_end;
  logic [IW-1:0]          w_next_idx;
  logic [PAR_N*PAR_W-1:0] w_src;
  logic [PAR_W-1:0]       w_load_val;

  logic w_accept;
  logic w_conv_init;
  logic w_conv_step;
  logic w_load;
  logic w_send;
  logic w_finish;

  assign busy    = r_busy;
  assign done    = r_done;
  assign uart_tx = r_tx;

  assign w_last_par  = (r_idx == IW'(PAR_N - 1));
  assign w_last_char = r_sep_sent && w_last_par;
  assign w_conv_last = (r_cnt == CW'(PAR_W - 1));

  // Non-final frames hand over one cycle early so LOAD overlaps the last stop
  // cycle; the terminator frame holds its stop bit fully before done.
  assign w_frame_end = (r_bit == 4'd10) &&
                       (r_baud == (w_last_char ? BW'(0) : BW'(1)));

  assign w_next_idx = w_accept ? '0 : r_idx + IW'(1);
  assign w_src      = w_accept ? params : r_snap;
  assign w_load_val = w_src[w_next_idx*PAR_W +: PAR_W];

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
    w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_shift[PAR_W-1]};
  end

  always_comb begin
    w_msd = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (w_bcd_next[4*k +: 4] != 4'd0) begin
        w_msd = DW'(k);
      end
    end
  end

  assign w_digit = r_bcd[{r_dptr, 2'b00} +: 4];

  always_comb begin
    if (r_dig_pend) begin
      w_char = {4'h3, w_digit};
    end else if (w_last_par) begin
      w_char = 8'h0A;
    end else begin
      w_char = 8'h5F;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_CONV;
      S_CONV: if (w_conv_last) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_frame_end) begin
          if (!r_sep_sent) begin
            w_state_nxt = S_LOAD;
          end else if (w_last_par) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_CONV;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept    = 1'b0;
    w_conv_init = 1'b0;
    w_conv_step = 1'b0;
    w_load      = 1'b0;
    w_send      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept    = start;
        w_conv_init = start;
      end
      S_CONV: w_conv_step = 1'b1;
      S_LOAD: w_load = 1'b1;
      S_SEND: begin
        w_send = 1'b1;
        if (w_frame_end && r_sep_sent) begin
          if (w_last_par) begin
            w_finish = 1'b1;
          end else begin
            w_conv_init = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_snap <= params;
      r_idx  <= '0;
    end else if (w_conv_init) begin
      r_idx <= w_next_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_dptr     <= '0;
      r_dig_pend <= 1'b0;
      r_sep_sent <= 1'b0;
    end else begin
      if (w_conv_init) begin
        r_shift <= w_load_val;
        r_bcd   <= '0;
        r_cnt   <= '0;
      end
      if (w_conv_step) begin
        r_shift <= r_shift << 1;
        r_bcd   <= w_bcd_next;
        r_cnt   <= r_cnt + CW'(1);
        if (w_conv_last) begin
          r_dptr     <= w_msd;
          r_dig_pend <= 1'b1;
          r_sep_sent <= 1'b0;
        end
      end
      if (w_load) begin
        if (r_dig_pend) begin
          if (r_dptr == '0) begin
            r_dig_pend <= 1'b0;
          end else begin
            r_dptr <= r_dptr - DW'(1);
          end
        end else begin
          r_sep_sent <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else if (w_load) begin
      r_frame <= {1'b1, w_char, 1'b0};
      r_baud  <= '0;
      r_bit   <= '0;
    end else if (w_send) begin
      if (r_baud == '0) begin
        if (r_bit != 4'd10) begin
          r_tx    <= r_frame[0];
          r_frame <= {1'b1, r_frame[9:1]};
          r_bit   <= r_bit + 4'd1;
          r_baud  <= BW'(CLK_DIV - 1);
        end
      end else begin
        r_baud <= r_baud - BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (w_finish) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
